// File: rtl/timer_pkg.sv
// Shared types and helpers for the timer/stopwatch controller.
// Contents: FSM state encodings, mode encodings, the packed MM:SS BCD struct,
// and the preset increment helpers (seconds wrap 59->00 without carry,
// minutes wrap at the configured maximum).
package timer_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] SEC_MAX_TENS = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  typedef enum logic {
    MODE_SW  = 1'b0,
    MODE_TMR = 1'b1
  } mode_t;

  typedef struct packed {
    logic [DIGIT_W-1:0] min_tens;
    logic [DIGIT_W-1:0] min_ones;
    logic [DIGIT_W-1:0] sec_tens;
    logic [DIGIT_W-1:0] sec_ones;
  } mmss_t;

  // Binary 0..99 to two BCD digits {tens, ones}.
  function automatic logic [7:0] to_bcd2(input int unsigned v);
    to_bcd2 = {4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Preset second +1: wraps 59 -> 00 and leaves the minutes alone.
  function automatic mmss_t preset_inc_sec(input mmss_t v);
    preset_inc_sec = v;
    if (v.sec_ones != 4'd9) begin
      preset_inc_sec.sec_ones = v.sec_ones + 4'd1;
    end else begin
      preset_inc_sec.sec_ones = '0;
      preset_inc_sec.sec_tens = (v.sec_tens == SEC_MAX_TENS) ? '0 : v.sec_tens + 4'd1;
    end
  endfunction

  // Preset minute +1: wraps max_bcd -> 00.
  function automatic mmss_t preset_inc_min(input mmss_t v, input logic [7:0] max_bcd);
    preset_inc_min = v;
    if ({v.min_tens, v.min_ones} == max_bcd) begin
      preset_inc_min.min_tens = '0;
      preset_inc_min.min_ones = '0;
    end else if (v.min_ones != 4'd9) begin
      preset_inc_min.min_ones = v.min_ones + 4'd1;
    end else begin
      preset_inc_min.min_ones = '0;
      preset_inc_min.min_tens = v.min_tens + 4'd1;
    end
  endfunction

endpackage

// File: rtl/timer_controller_if.sv
// Button-pulse / display-output bundle of the timer controller.
// master: drives the one-cycle button pulses, reads the display/status outputs.
// slave : the controller side.
interface timer_controller_if;
  import timer_pkg::*;

  logic               i_start_pulse;
  logic               i_clear_pulse;
  logic               i_mode_pulse;
  logic               i_inc_min_pulse;
  logic               i_inc_sec_pulse;
  logic [DIGIT_W-1:0] o_min_tens;
  logic [DIGIT_W-1:0] o_min_ones;
  logic [DIGIT_W-1:0] o_sec_tens;
  logic [DIGIT_W-1:0] o_sec_ones;
  logic [1:0]         o_state;
  logic               o_mode;
  logic               o_expired;

  modport master (
    output i_start_pulse, i_clear_pulse, i_mode_pulse, i_inc_min_pulse, i_inc_sec_pulse,
    input  o_min_tens, o_min_ones, o_sec_tens, o_sec_ones, o_state, o_mode, o_expired
  );

  modport slave (
    input  i_start_pulse, i_clear_pulse, i_mode_pulse, i_inc_min_pulse, i_inc_sec_pulse,
    output o_min_tens, o_min_ones, o_sec_tens, o_sec_ones, o_state, o_mode, o_expired
  );
endinterface

// File: rtl/bcd_mmss_counter.sv
// MM:SS BCD up/down counter.
// Ports: i_clk, i_rst (sync, active-high), i_load/i_load_val (load has priority),
// i_en (one step), i_down (1 = count down), o_count, o_is_zero (00:00),
// o_is_max (MAX_MIN:59). Counting saturates at 00:00 down and MAX_MIN:59 up.
module bcd_mmss_counter
  import timer_pkg::*;
#(
  parameter int unsigned MAX_MIN = 59
) (
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_load,
  input  mmss_t i_load_val,
  input  logic  i_en,
  input  logic  i_down,
  output mmss_t o_count,
  output logic  o_is_zero,
  output logic  o_is_max
);

  localparam logic [7:0] MAX_BCD = to_bcd2(MAX_MIN);

  mmss_t cnt_q;
  mmss_t cnt_up;
  mmss_t cnt_dn;

  always_comb begin
    cnt_up = cnt_q;
    if (cnt_q.sec_ones != 4'd9) begin
      cnt_up.sec_ones = cnt_q.sec_ones + 4'd1;
    end else begin
      cnt_up.sec_ones = '0;
      if (cnt_q.sec_tens != SEC_MAX_TENS) begin
        cnt_up.sec_tens = cnt_q.sec_tens + 4'd1;
      end else begin
        cnt_up.sec_tens = '0;
        if (cnt_q.min_ones != 4'd9) begin
          cnt_up.min_ones = cnt_q.min_ones + 4'd1;
        end else begin
          cnt_up.min_ones = '0;
          cnt_up.min_tens = cnt_q.min_tens + 4'd1;
        end
      end
    end
  end

  always_comb begin
    cnt_dn = cnt_q;
    if (cnt_q.sec_ones != 4'd0) begin
      cnt_dn.sec_ones = cnt_q.sec_ones - 4'd1;
    end else begin
      cnt_dn.sec_ones = 4'd9;
      if (cnt_q.sec_tens != 4'd0) begin
        cnt_dn.sec_tens = cnt_q.sec_tens - 4'd1;
      end else begin
        cnt_dn.sec_tens = SEC_MAX_TENS;
        if (cnt_q.min_ones != 4'd0) begin
          cnt_dn.min_ones = cnt_q.min_ones - 4'd1;
        end else begin
          cnt_dn.min_ones = 4'd9;
          cnt_dn.min_tens = cnt_q.min_tens - 4'd1;
        end
      end
    end
  end

  assign o_is_zero = (cnt_q == '0);
  assign o_is_max  = ({cnt_q.min_tens, cnt_q.min_ones} == MAX_BCD) &&
                     (cnt_q.sec_tens == SEC_MAX_TENS) && (cnt_q.sec_ones == 4'd9);
  assign o_count   = cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (i_load) begin
      cnt_q <= i_load_val;
    end else if (i_en) begin
      if (i_down && !o_is_zero) begin
        cnt_q <= cnt_dn;
      end else if (!i_down && !o_is_max) begin
        cnt_q <= cnt_up;
      end
    end
  end

endmodule

// File: rtl/timer_controller.sv
// Timer/stopwatch central sequencer.
// Ports: i_clk, i_rst (sync, active-high), bus (timer_controller_if.slave):
//   button pulses in (start, clear, mode, inc_min, inc_sec), BCD MM:SS,
//   state, mode and expired out. Same-cycle pulse priority:
//   clear > start > mode > inc_min > inc_sec.
// Optional feature macro: TIMER_LAP_EN (stopwatch lap freeze on the mode button).
module timer_controller
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned MAX_MIN  = 59
) (
  input  logic i_clk,
  input  logic i_rst,
  timer_controller_if.slave bus
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0] MAX_BCD = to_bcd2(MAX_MIN);

  state_t        state;
  mode_t         mode;
  mmss_t         preset;
  logic [PW-1:0] presc;
  logic          expired;

  mmss_t count;
  mmss_t load_val;
  mmss_t disp;
  logic  load;
  logic  en;
  logic  is_zero;
  logic  is_max;
  logic  tick;
  logic  done_hit;

  logic clr_p, start_p, mode_p, min_p, sec_p;
  assign clr_p   = bus.i_clear_pulse;
  assign start_p = bus.i_start_pulse;
  assign mode_p  = bus.i_mode_pulse;
  assign min_p   = bus.i_inc_min_pulse;
  assign sec_p   = bus.i_inc_sec_pulse;

  assign tick = (state == ST_RUN) && (presc == PRESC_LAST);
  // Timer hits zero on the tick that leaves 00:01; stopwatch stops at max.
  assign done_hit = tick && (((mode == MODE_SW) && is_max) ||
                             ((mode == MODE_TMR) && (count == mmss_t'(16'h0001))));

  always_comb begin
    load     = 1'b0;
    load_val = preset;
    en       = 1'b0;
    if (clr_p) begin
      load     = 1'b1;
      load_val = (mode == MODE_TMR) ? preset : '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!start_p) begin
            if (mode_p) begin
              load     = 1'b1;
              load_val = (mode == MODE_SW) ? preset : '0;
            end else if (mode == MODE_TMR) begin
              if (min_p) begin
                load     = 1'b1;
                load_val = preset_inc_min(count, MAX_BCD);
              end else if (sec_p) begin
                load     = 1'b1;
                load_val = preset_inc_sec(count);
              end
            end
          end
        end
        ST_RUN: en = !start_p && tick;
        default: ;
      endcase
    end
  end

  bcd_mmss_counter #(
    .MAX_MIN (MAX_MIN)
  ) u_counter (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (load),
    .i_load_val (load_val),
    .i_en       (en),
    .i_down     (mode == MODE_TMR),
    .o_count    (count),
    .o_is_zero  (is_zero),
    .o_is_max   (is_max)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      mode    <= MODE_SW;
      preset  <= '0;
      presc   <= '0;
      expired <= 1'b0;
    end else begin
      presc   <= '0;
      expired <= 1'b0;
      if (clr_p) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_p) begin
              if (!((mode == MODE_TMR) && is_zero)) state <= ST_RUN;
            end else if (mode_p) begin
              mode <= (mode == MODE_SW) ? MODE_TMR : MODE_SW;
            end else if (mode == MODE_TMR) begin
              if (min_p) begin
                preset <= preset_inc_min(preset, MAX_BCD);
              end else if (sec_p) begin
                preset <= preset_inc_sec(preset);
              end
            end
          end
          ST_RUN: begin
            if (start_p) begin
              state <= ST_PAUSE;
            end else if (done_hit) begin
              state   <= ST_DONE;
              expired <= 1'b1;
            end else begin
              presc <= tick ? '0 : presc + PW'(1);
            end
          end
          ST_PAUSE: begin
            if (start_p) state <= ST_RUN;
          end
          ST_DONE: begin
            if (start_p) state <= ST_IDLE;
            else         expired <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef TIMER_LAP_EN
  logic  lap_on;
  mmss_t lap_val;

  // Freeze survives RUN<->PAUSE; any other exit from RUN/PAUSE releases it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lap_on  <= 1'b0;
      lap_val <= '0;
    end else if (clr_p) begin
      lap_on <= 1'b0;
    end else if (state == ST_RUN) begin
      if (!start_p) begin
        if (done_hit) begin
          lap_on <= 1'b0;
        end else if (mode_p && (mode == MODE_SW)) begin
          lap_on  <= !lap_on;
          lap_val <= count;
        end
      end
    end else if (state != ST_PAUSE) begin
      lap_on <= 1'b0;
    end
  end

  assign disp = lap_on ? lap_val : count;
`else
  assign disp = count;
`endif

  assign bus.o_min_tens = disp.min_tens;
  assign bus.o_min_ones = disp.min_ones;
  assign bus.o_sec_tens = disp.sec_tens;
  assign bus.o_sec_ones = disp.sec_ones;
  assign bus.o_state    = state;
  assign bus.o_mode     = mode;
  assign bus.o_expired  = expired;

endmodule

// File: doc/timer_controller.md
Name: timer_controller

Overview:
Central sequencer for the timer/stopwatch. Consumes one-cycle button pulses from the per-button debouncers, runs the mode/run state machine, generates the 1 Hz count enable from the system clock, and owns the MM:SS BCD count and timer preset. Its outputs feed the seven-segment display driver and the alarm/LED logic.

Parameters:
TICK_DIV, 100_000_000, i_clk cycles per count second (bench uses 4)
MAX_MIN, 59, highest minute value (BCD, 00..99 legal)

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous active-high reset
i_start_pulse  input  1  start/stop toggle, one-cycle pulse
i_clear_pulse  input  1  clear/reload, one-cycle pulse
i_mode_pulse  input  1  stopwatch/timer toggle, one-cycle pulse
i_inc_min_pulse  input  1  preset minute +1, one-cycle pulse
i_inc_sec_pulse  input  1  preset second +1, one-cycle pulse
o_min_tens  output  4  BCD minute tens
o_min_ones  output  4  BCD minute ones
o_sec_tens  output  4  BCD second tens (0..5)
o_sec_ones  output  4  BCD second ones
o_state  output  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
o_mode  output  1  0 stopwatch (count up), 1 timer (count down)
o_expired  output  1  high while in DONE

Behaviour:
- Single clock domain i_clk; i_rst synchronous, active-high; one clock, no gating.
- Reset: state IDLE, mode 0, count 00:00, preset 00:00, prescaler 0, all outputs 0.
- All outputs registered; a pulse at cycle N is reflected on outputs at cycle N+1.
- Same-cycle pulse priority: clear > start > mode > inc_min > inc_sec; lower-priority pulses in that cycle ignored.
- Prescaler: counts 0..TICK_DIV-1 only in RUN; held at 0 in other states; cleared on every entry to RUN. tick = (prescaler == TICK_DIV-1) in RUN; first tick TICK_DIV cycles after entering RUN.
- IDLE: start -> RUN, except timer mode with count 00:00 (stays IDLE). mode -> toggle o_mode, count loads 00:00 (to stopwatch) or preset (to timer). inc_min/inc_sec honoured only in timer mode: increment preset and count together; seconds wrap 59->00 without carry; minutes wrap MAX_MIN->00.
- RUN: start -> PAUSE (count holds). clear -> IDLE. tick: stopwatch +1 s with BCD carry (sec 59->00, min +1); timer -1 s with BCD borrow (sec 00->59, min -1).
- Stopwatch at MAX_MIN:59 on tick -> count holds, DONE. Timer reaching 00:00 on tick -> DONE same cycle.
- PAUSE: start -> RUN (prescaler restarts at 0). clear -> IDLE.
- DONE: o_expired=1. start or clear -> IDLE.
- Clear (any state): stopwatch count <- 00:00; timer count <- preset; state IDLE.
- mode and inc pulses ignored outside IDLE (see LAP_EN).
- Reset mid-RUN: next cycle fully at reset values, preset lost.

Optional Feature:
Macro TIMER_LAP_EN. With it: in stopwatch RUN, i_mode_pulse toggles a lap freeze; BCD outputs hold the value at freeze while the internal count continues; second press, clear, or leaving RUN releases the freeze. PAUSE preserves the freeze. Without it: i_mode_pulse ignored outside IDLE, outputs always show live count.

Decomposition:
- Package timer_pkg: state encodings (ST_IDLE..ST_DONE), mode encodings (MODE_SW, MODE_TMR), BCD digit width 4, SEC_MAX_TENS=5.
- Sub-module bcd_mmss_counter: up/down MM:SS BCD counter with load, enable, direction, MAX_MIN parameter; outputs is_zero and is_max flags. Controller keeps FSM, prescaler, preset, priority logic.

Test Plan:
- TICK_DIV=4, stopwatch: start, wait 12 cycles -> count 00:03, o_state 01; start -> PAUSE, 20 idle cycles, count stays 00:03.
- Timer: mode, inc_sec x3, start -> 00:03,00:02,00:01,00:00 at 4-cycle spacing; o_state 11 and o_expired 1 on the 00:00 cycle.
- Borrow/carry: timer preset 01:00 -> first tick 00:59. Stopwatch forced to 00:59 -> first tick 01:00. MAX_MIN=1 stopwatch at 01:59 -> DONE, holds 01:59.
- Same-cycle start+clear in RUN -> IDLE, timer count = preset. Start in timer mode at 00:00 -> stays IDLE.
- i_rst asserted mid-RUN for 1 cycle -> next cycle IDLE, mode 0, 00:00, o_expired 0. inc_sec in RUN -> ignored.
- TIMER_LAP_EN: stopwatch RUN, mode at 00:02 -> outputs hold 00:02 while internal count reaches 00:05; mode again -> outputs 00:05 next cycle.
